syscall_unit: RTL

Services MIPS `syscall` instructions flagged by the decode stage's `syscall` control signal. It reads the request code from `$v0` and the argument from `$a0`. Output characters go out on a byte stream with a valid/ready handshake, and the unit can stop the processor. While a request is in progress it freezes the pipeline through `stall`. It sits beside the register file and the execute stage.

---
 rtl/syscall_unit.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/syscall_unit.sv
// syscall_unit: services MIPS syscalls print_int (1), exit (10) and print_char (11).
// print_int converts |a0| to BCD by double-dabble, then streams sign and digits
// out over a valid/ready byte port. Unsupported codes pulse bad_code for one cycle.
// Optional feature macro SYSCALL_NEWLINE_EN: print_int appends a 0x0A byte.
module syscall_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        syscall_req,
    input  logic [31:0] v0,
    input  logic [31:0] a0,
    output logic        stall,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        halt,
    output logic        bad_code
);

    typedef enum logic [2:0] {
        StIdle,
        StConvert,
        StSign,
        StEmit,
        StChar,
        StDone,
        StHalted
`ifdef SYSCALL_NEWLINE_EN
        , StNl
`endif
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] arg_q, arg_d;
    logic [31:0] mag_q, mag_d;
    logic [39:0] bcd_q, bcd_d;
    logic [39:0] bcd_adj;
    logic [39:0] bcd_sh;
    logic [4:0]  cnt_q, cnt_d;
    logic [3:0]  ptr_q, ptr_d;
    logic        neg_q, neg_d;
    logic        bad_q, bad_d;
    logic        fire;

    // Index of the most significant nonzero BCD digit; 0 when the value is 0.
    function automatic logic [3:0] msd_ptr(input logic [39:0] b);
        logic [3:0] p;
        p = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (b[i*4 +: 4] != 4'd0) p = 4'(i);
        end
        return p;
    endfunction

    // Double-dabble correction: add 3 to every digit >= 5 before the shift.
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < 10; i++) begin
            bcd_adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? bcd_q[i*4 +: 4] + 4'd3
                                                          : bcd_q[i*4 +: 4];
        end
    end

    assign bcd_sh = bcd_q >> {ptr_q, 2'b00};
    assign fire   = out_valid && out_ready;

    // Next-state logic and datapath updates.
    always_comb begin
        state_d = state_q;
        arg_d   = arg_q;
        mag_d   = mag_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        neg_d   = neg_q;
        bad_d   = bad_q;
        unique case (state_q)
            StIdle: begin
                if (syscall_req) begin
                    arg_d = a0;
                    bad_d = 1'b0;
                    case (v0)
                        32'd11: state_d = StChar;
                        32'd1: begin
                            state_d = StConvert;
                            neg_d   = a0[31];
                            mag_d   = a0[31] ? (~a0 + 32'd1) : a0;
                            bcd_d   = '0;
                            cnt_d   = '0;
                        end
                        32'd10:  state_d = StHalted;
                        default: begin
                            state_d = StDone;
                            bad_d   = 1'b1;
                        end
                    endcase
                end
            end
            StConvert: begin
                bcd_d = {bcd_adj[38:0], mag_q[31]};
                mag_d = {mag_q[30:0], 1'b0};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    ptr_d   = msd_ptr(bcd_d);
                    state_d = neg_q ? StSign : StEmit;
                end
            end
            StSign: begin
                if (fire) state_d = StEmit;
            end
            StEmit: begin
                if (fire) begin
                    if (ptr_q == 4'd0) begin
`ifdef SYSCALL_NEWLINE_EN
                        state_d = StNl;
`else
                        state_d = StDone;
`endif
                    end else begin
                        ptr_d = ptr_q - 4'd1;
                    end
                end
            end
            StChar: begin
                if (fire) state_d = StDone;
            end
`ifdef SYSCALL_NEWLINE_EN
            StNl: begin
                if (fire) state_d = StDone;
            end
`endif
            StDone: begin
                state_d = StIdle;
                bad_d   = 1'b0;
            end
            StHalted: state_d = StHalted;
            default:  state_d = StIdle;
        endcase
    end

    // Output decode: depends only on state and latched data, never on out_ready.
    always_comb begin
        out_valid = 1'b0;
        out_data  = 8'h00;
        unique case (state_q)
            StSign: begin
                out_valid = 1'b1;
                out_data  = 8'h2D;
            end
            StEmit: begin
                out_valid = 1'b1;
                out_data  = 8'h30 + {4'h0, bcd_sh[3:0]};
            end
            StChar: begin
                out_valid = 1'b1;
                out_data  = arg_q[7:0];
            end
`ifdef SYSCALL_NEWLINE_EN
            StNl: begin
                out_valid = 1'b1;
                out_data  = 8'h0A;
            end
`endif
            default: ;
        endcase
    end

    assign stall    = ((state_q == StIdle) && syscall_req) ||
                      ((state_q != StIdle) && (state_q != StDone));
    assign halt     = (state_q == StHalted);
    assign bad_code = (state_q == StDone) && bad_q;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            arg_q   <= '0;
            mag_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            neg_q   <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            arg_q   <= arg_d;
            mag_q   <= mag_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            neg_q   <= neg_d;
            bad_q   <= bad_d;
        end
    end

endmodule
